ttfs_encoder: RTL and testbench
===============================

Name: ttfs_encoder

Overview:
- Time-to-first-spike encoder; the inverse of the TTD spike-time decoder.
- Takes one latency code per neuron and replays it as a single spike at the coded time within a timing window.
- Drives stimulus spikes into the BSNN neuron array. Its window timing matches the TTD decoder, so a ttfs_encoder → ttd loop reproduces the codes.

Parameters:
- TTD_WIDTH, 5: time-field width; window length is 2^TTD_WIDTH slots.
- N_NEURONS, 4: number of spike lanes.
- EARLY_FINISH, 1: when 1, the window ends as soon as every enabled lane has fired.

Ports:
- CLK  in  1  clock, rising edge.
- RES  in  1  reset, asynchronous, active-high.
- start  in  1  request a window; sampled only when busy=0.
- abort  in  1  synchronous cancel of the running window.
- en  in  1  time-advance enable; 0 stalls the window.
- codes  in  N_NEURONS*(TTD_WIDTH+1)  per-lane code; lane i occupies bits [i*(TTD_WIDTH+1) +: TTD_WIDTH+1].
- spikes  out  N_NEURONS  registered one-cycle spike pulses.
- busy  out  1  high while a window is running.
- done  out  1  one-cycle pulse marking window completion.
- cnt  out  TTD_WIDTH  current slot index, for debug and alignment.

Behaviour:
- Code format: bit TTD_WIDTH is the fire-enable; bits [TTD_WIDTH-1:0] are the spike slot t. Enable=0 means the lane stays silent regardless of t.
- Reset (asynchronous, RES=1): state IDLE, spikes=0, busy=0, done=0, cnt=0, all pending flags=0. Reset mid-window discards the window with no done pulse.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches codes, sets pending[i]=enable[i], cnt<=0, busy<=1, state RUN.
  - start is ignored when busy=1.
- RUN, each edge with en=1:
  - spikes[i] <= pending[i] & (t[i]==cnt); matching pending flags clear.
  - cnt <= cnt+1.
- Latency: a lane with slot t pulses spikes[i] for exactly one cycle, right after edge E(t+1), provided en was held at 1. Each lane fires at most once per window.
- RUN with en=0: cnt and pending hold, spikes<=0, done<=0.
- Window end, evaluated at the advancing edge:
  - (a) cnt == 2^TTD_WIDTH-1; or
  - (b) EARLY_FINISH=1 and no pending flag remains after this edge's matches.
  - At that edge: state<=IDLE, busy<=0, done<=1. done therefore coincides with the final spikes.
- All lanes silent with EARLY_FINISH=1: done after E1, no spikes.
- Back-to-back: start sampled while done=1 (busy=0) is accepted. Inter-window gap is one cycle.
- abort=1 in RUN: next edge gives state IDLE, busy=0, spikes=0, pending cleared, no done. abort has priority over the window-end and spike logic. abort in IDLE is a no-op.
- Same slot on several lanes: all of those lanes pulse in the same cycle.
- cnt never wraps inside a window; the window ends at max slot.
- No arithmetic beyond the TTD_WIDTH-bit increment and equality compares.

Decomposition:
- Shared package ttd_pkg holds:
  - TTD_WIDTH and N_NEURONS defaults.
  - Code field positions: CODE_EN_BIT, CODE_T_MSB.
  - The state enum.
  - Helpers code_en() and code_t().
  - The same package is reused by the ttd decoder.
- One natural sub-module, ttfs_lane, one instance per neuron: pending flag, slot register, equality compare, spike register. The top block holds the FSM and the counter.

Test Plan:
- TTD_WIDTH=5, EARLY_FINISH=1, codes lane0..3 = {en1,t=0}, {en1,t=3}, {en1,t=3}, {en0,t=7}, start at E0, en=1 → spikes 0001 after E1; 0110 after E4; done with the E4 spikes; lane3 never fires; busy low after E4.
- EARLY_FINISH=0, all lanes {en1,t=31} → spikes 1111 after E32, done coincident, no spike earlier.
- Lane0 {en1,t=5}, en=0 for 3 cycles starting after E2 → lane0 spike delayed 3 cycles (after E9); cnt frozen during the stall.
- abort after E2 with lane0 {en1,t=10} → busy=0 after E3, no spike, no done; a new start is accepted immediately afterwards.
- start held high continuously, lane0 {en1,t=1} → windows repeat with a one-cycle gap; start pulses during busy are ignored.
- RES asserted asynchronously mid-window → outputs 0 immediately; after release, no stale spike appears and the next window behaves nominally.

Source files
------------

// File: rtl/ttd_pkg.sv
// Shared definitions for the time-to-first-spike encoder and the TTD decoder:
// default widths, code field layout, FSM state type and code field helpers.
package ttd_pkg;

    localparam int unsigned DEF_TTD_WIDTH = 5;
    localparam int unsigned DEF_N_NEURONS = 4;

    // Code layout: {fire_enable, slot[TTD_WIDTH-1:0]}
    localparam int unsigned CODE_EN_BIT = DEF_TTD_WIDTH;
    localparam int unsigned CODE_T_MSB  = DEF_TTD_WIDTH - 1;

    typedef logic [DEF_TTD_WIDTH:0] ttd_code_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ttd_state_e;

    function automatic logic code_en(input ttd_code_t c);
        return c[CODE_EN_BIT];
    endfunction

    function automatic logic [DEF_TTD_WIDTH-1:0] code_t(input ttd_code_t c);
        return c[CODE_T_MSB:0];
    endfunction

endpackage

// File: rtl/ttfs_encoder_lane.sv
// One spike lane: holds the latched slot and pending flag, and emits a single
// registered spike when the window counter reaches the latched slot.
module ttfs_lane
    import ttd_pkg::*;
#(
    parameter int unsigned TTD_WIDTH = DEF_TTD_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic                 adv_i,
    input  logic                 fire_en_i,
    input  logic [TTD_WIDTH-1:0] slot_i,
    input  logic [TTD_WIDTH-1:0] cnt_i,
    output logic                 pend_o,
    output logic                 hit_o,
    output logic                 spike_o
);

    logic                 pend_q,  pend_d;
    logic [TTD_WIDTH-1:0] slot_q,  slot_d;
    logic                 spike_q, spike_d;

    assign hit_o   = pend_q && (slot_q == cnt_i);
    assign pend_o  = pend_q;
    assign spike_o = spike_q;

    // Next-state: latch on window start, drop on abort, fire once on a slot match
    always_comb begin
        pend_d  = pend_q;
        slot_d  = slot_q;
        spike_d = 1'b0;
        if (load_i) begin
            pend_d = fire_en_i;
            slot_d = slot_i;
        end else if (clear_i) begin
            pend_d = 1'b0;
        end else if (adv_i) begin
            spike_d = hit_o;
            if (hit_o) begin
                pend_d = 1'b0;
            end
        end
    end

    // Lane state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            slot_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            spike_q <= spike_d;
        end
    end

endmodule

// File: rtl/ttfs_encoder.sv
// Time-to-first-spike encoder: replays one latency code per lane as a single
// spike at the coded slot of a 2^TTD_WIDTH-slot window.
module ttfs_encoder
    import ttd_pkg::*;
#(
    parameter int unsigned TTD_WIDTH    = DEF_TTD_WIDTH,
    parameter int unsigned N_NEURONS    = DEF_N_NEURONS,
    parameter int unsigned EARLY_FINISH = 1
) (
    input  logic                               CLK,
    input  logic                               RES,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               en,
    input  logic [N_NEURONS*(TTD_WIDTH+1)-1:0] codes,
    output logic [N_NEURONS-1:0]               spikes,
    output logic                               busy,
    output logic                               done,
    output logic [TTD_WIDTH-1:0]               cnt
);

    ttd_state_e           state_q, state_d;
    logic [TTD_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 done_q,  done_d;

    logic                 load;
    logic                 clear;
    logic                 adv;
    logic [N_NEURONS-1:0] pend;
    logic [N_NEURONS-1:0] hit;

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign cnt  = cnt_q;

    // Window FSM: start latches codes, abort cancels, the advancing edge may end the window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (en) begin
                    adv   = 1'b1;
                    cnt_d = cnt_q + TTD_WIDTH'(1);
                    // Early finish looks at pending flags left after this edge's matches
                    if ((cnt_q == '1) ||
                        ((EARLY_FINISH != 0) && ((pend & ~hit) == '0))) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, slot counter and done pulse registers
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
        ttfs_lane #(
            .TTD_WIDTH (TTD_WIDTH)
        ) u_lane (
            .clk_i     (CLK),
            .rst_i     (RES),
            .load_i    (load),
            .clear_i   (clear),
            .adv_i     (adv),
            .fire_en_i (codes[g*(TTD_WIDTH+1) + TTD_WIDTH]),
            .slot_i    (codes[g*(TTD_WIDTH+1) +: TTD_WIDTH]),
            .cnt_i     (cnt_q),
            .pend_o    (pend[g]),
            .hit_o     (hit[g]),
            .spike_o   (spikes[g])
        );
    end

endmodule

// File: tb/tb_ttfs_encoder.sv
// Scoreboard bench for ttfs_encoder: expected spike/done events are queued
// when a window is started and compared at the negedge of the edge they are due.
module tb_ttfs_encoder;

    localparam int unsigned TW = 5;
    localparam int unsigned NN = 4;

    typedef struct {
        int unsigned at;
        logic [3:0]  spk;
        logic        dn;
        logic        bz;
    } ev_t;

    logic                CLK = 1'b0;
    logic                RES = 1'b0;
    logic                start = 1'b0;
    logic                start_nf = 1'b0;
    logic                abort = 1'b0;
    logic                en = 1'b1;
    logic [NN*(TW+1)-1:0] codes = '0;
    logic [NN*(TW+1)-1:0] codes_nf = '0;

    logic [NN-1:0] spikes,  spikes_nf;
    logic          busy,    busy_nf;
    logic          done,    done_nf;
    logic [TW-1:0] cnt,     cnt_nf;

    int unsigned edge_n = 0;
    int unsigned total  = 0;
    int unsigned bad    = 0;
    int unsigned e0;
    int unsigned k;

    ev_t q0[$];
    ev_t qn[$];

    ttfs_encoder #(
        .TTD_WIDTH    (TW),
        .N_NEURONS    (NN),
        .EARLY_FINISH (1)
    ) dut (
        .CLK    (CLK),
        .RES    (RES),
        .start  (start),
        .abort  (abort),
        .en     (en),
        .codes  (codes),
        .spikes (spikes),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    ttfs_encoder #(
        .TTD_WIDTH    (TW),
        .N_NEURONS    (NN),
        .EARLY_FINISH (0)
    ) dut_nf (
        .CLK    (CLK),
        .RES    (RES),
        .start  (start_nf),
        .abort  (abort),
        .en     (en),
        .codes  (codes_nf),
        .spikes (spikes_nf),
        .busy   (busy_nf),
        .done   (done_nf),
        .cnt    (cnt_nf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [TW:0] mk(input logic e, input int unsigned t);
        logic [31:0] tv;
        tv = t;
        return {e, tv[TW-1:0]};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push0(input int unsigned at, input logic [3:0] s, input logic d, input logic b);
        ev_t ev;
        ev.at = at; ev.spk = s; ev.dn = d; ev.bz = b;
        q0.push_back(ev);
    endtask

    task automatic pushn(input int unsigned at, input logic [3:0] s, input logic d, input logic b);
        ev_t ev;
        ev.at = at; ev.spk = s; ev.dn = d; ev.bz = b;
        qn.push_back(ev);
    endtask

    // Early-finish instance monitor
    always @(negedge CLK) begin
        if (q0.size() != 0 && q0[0].at == edge_n) begin
            check("spk",  32'(spikes), 32'(q0[0].spk));
            check("done", 32'(done),   32'(q0[0].dn));
            check("busy", 32'(busy),   32'(q0[0].bz));
            void'(q0.pop_front());
        end else begin
            check("quiet_spk",  32'(spikes), 32'd0);
            check("quiet_done", 32'(done),   32'd0);
        end
    end

    // Full-window instance monitor
    always @(negedge CLK) begin
        if (qn.size() != 0 && qn[0].at == edge_n) begin
            check("nf_spk",  32'(spikes_nf), 32'(qn[0].spk));
            check("nf_done", 32'(done_nf),   32'(qn[0].dn));
            check("nf_busy", 32'(busy_nf),   32'(qn[0].bz));
            void'(qn.pop_front());
        end else begin
            check("nf_quiet_spk",  32'(spikes_nf), 32'd0);
            check("nf_quiet_done", 32'(done_nf),   32'd0);
        end
    end

    initial begin
        #1 RES = 1'b1;
        tick(2);
        check("rst_spk",  32'(spikes), 32'd0);
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_cnt",  32'(cnt),    32'd0);
        check("rst_nf_busy", 32'(busy_nf), 32'd0);
        RES = 1'b0;
        tick(1);

        // Mixed slots, a silent lane, codes changed after latch
        codes = {mk(0, 7), mk(1, 3), mk(1, 3), mk(1, 0)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 1, 4'b0001, 1'b0, 1'b1);
        push0(e0 + 4, 4'b0110, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        codes = {mk(1, 1), mk(1, 1), mk(1, 1), mk(1, 1)};
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cnt0", 32'(cnt),  32'd0);
        tick(1);
        check("t1_cnt1", 32'(cnt),  32'd1);
        tick(5);
        check("t1_idle", 32'(busy), 32'd0);

        // All lanes silent: done right after E1
        codes = {mk(0, 0), mk(0, 5), mk(0, 9), mk(0, 31)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 1, 4'b0000, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        tick(3);

        // Stall for three edges after E2
        codes = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1, 5)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 9, 4'b0001, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        tick(2);
        check("stall_pre_cnt", 32'(cnt), 32'd2);
        en = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick(1);
            check("stall_cnt",  32'(cnt),  32'd2);
            check("stall_busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
        tick(6);

        // Abort after E2, then an immediate new window
        codes = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1, 10)};
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        abort = 1'b1;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        codes = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1, 2)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 3, 4'b0001, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        tick(5);

        // abort while idle does not block a start
        codes = {mk(1, 1), mk(0, 0), mk(0, 0), mk(0, 0)};
        start = 1'b1;
        abort = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 2, 4'b1000, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tick(4);

        // start held high: windows repeat with a one-cycle gap
        codes = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1, 1)};
        start = 1'b1;
        k = edge_n;
        for (int unsigned n = 0; n < 3; n++) push0(k + 3 + 3 * n, 4'b0001, 1'b1, 1'b0);
        tick(3);
        check("gap_busy", 32'(busy), 32'd0);
        tick(1);
        check("reaccept_busy", 32'(busy), 32'd1);
        tick(3);
        start = 1'b0;
        tick(5);

        // Asynchronous reset mid-window while a spike is showing
        codes = {mk(0, 0), mk(0, 0), mk(1, 1), mk(1, 8)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 2, 4'b0010, 1'b0, 1'b1);
        tick(1);
        start = 1'b0;
        tick(2);
        #6 RES = 1'b1;
        #1;
        check("ares_spk",  32'(spikes), 32'd0);
        check("ares_busy", 32'(busy),   32'd0);
        check("ares_done", 32'(done),   32'd0);
        check("ares_cnt",  32'(cnt),    32'd0);
        tick(2);
        RES = 1'b0;
        tick(12);
        codes = {mk(0, 0), mk(1, 4), mk(0, 0), mk(0, 0)};
        start = 1'b1;
        e0 = edge_n + 1;
        push0(e0 + 5, 4'b0100, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        tick(7);

        // Full window without early finish: all lanes at the last slot
        codes_nf = {mk(1, 31), mk(1, 31), mk(1, 31), mk(1, 31)};
        start_nf = 1'b1;
        e0 = edge_n + 1;
        pushn(e0 + 32, 4'b1111, 1'b1, 1'b0);
        tick(1);
        start_nf = 1'b0;
        tick(34);

        // Without early finish the window runs to the last slot after an early spike
        codes_nf = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1, 2)};
        start_nf = 1'b1;
        e0 = edge_n + 1;
        pushn(e0 + 3,  4'b0001, 1'b0, 1'b1);
        pushn(e0 + 32, 4'b0000, 1'b1, 1'b0);
        tick(1);
        start_nf = 1'b0;
        tick(31);
        check("nf_cnt_max",  32'(cnt_nf),  32'd31);
        check("nf_busy_max", 32'(busy_nf), 32'd1);
        tick(4);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("qn_drained", 32'(qn.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
